// File: rtl/bn_res_pipe.sv
// bn_res_pipe: batch-norm plus residual stage, placed between partial_sum and RPReLU.
//   y[i] = sat((bn_a[i]*data_in[i] + bn_b[i] + res[i % FM_DEPTH]) >>> shift_q)
// The stage is a two-register pipeline with valid/ready backpressure. The right shift
// rounds half up, and the result saturates to a signed DATA_WIDTH value.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   mode            0 = reload (shift_cfg is captured and the pipeline is flushed), 1 = calculate
//   shift_cfg       output right shift
//   res_en          enables the residual add; sampled together with data_in
//   data_in/data_e/data_ready     input beat (CHANNEL_NUM signed lanes)
//   bn_a, bn_b      per-channel scale and bias
//   res             residual vector, replicated modulo FM_DEPTH across channels
//   data_out/data_e_out/out_ready output beat
//   sat_flag        at least one lane of the current output beat was clamped
//   sat_cnt         count of retired beats that had sat_flag set; saturates at its maximum;
//                   cleared when mode falls
module bn_res_pipe #(
  parameter int DATA_WIDTH  = 16,
  parameter int PARA_WIDTH  = 16,
  parameter int CHANNEL_NUM = 256,
  parameter int FM_DEPTH    = 128,
  parameter int SHIFT_W     = 4,
  parameter int CNT_W       = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              mode,
  input  logic [SHIFT_W-1:0]                shift_cfg,
  input  logic                              res_en,
  input  logic [DATA_WIDTH*CHANNEL_NUM-1:0] data_in,
  input  logic                              data_e,
  output logic                              data_ready,
  input  logic [PARA_WIDTH*CHANNEL_NUM-1:0] bn_a,
  input  logic [PARA_WIDTH*CHANNEL_NUM-1:0] bn_b,
  input  logic [DATA_WIDTH*FM_DEPTH-1:0]    res,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] data_out,
  output logic                              data_e_out,
  input  logic                              out_ready,
  output logic                              sat_flag,
  output logic [CNT_W-1:0]                  sat_cnt
);

  localparam int P_W   = DATA_WIDTH + PARA_WIDTH;
  localparam int Q_W   = ((PARA_WIDTH > DATA_WIDTH) ? PARA_WIDTH : DATA_WIDTH) + 1;
  localparam int ACC_W = DATA_WIDTH + PARA_WIDTH + 2;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ONE = 1;

  if (CHANNEL_NUM % FM_DEPTH != 0) begin : g_cfg_err
    $error("bn_res_pipe: CHANNEL_NUM must be a multiple of FM_DEPTH");
  end

  logic                   stall;
  logic                   adv;
  logic                   accept;
  logic                   retire;
  logic                   s1_v;
  logic                   mode_q;
  logic [SHIFT_W-1:0]     shift_q;
  logic signed [ACC_W-1:0] rnd;
  logic [CHANNEL_NUM-1:0] clamped;

  assign stall      = data_e_out && !out_ready;
  assign adv        = mode && !stall;
  assign data_ready = adv;
  assign accept     = adv && data_e;
  assign retire     = data_e_out && out_ready;

  // Rounding constant for round-half-up. Shift 0 adds nothing.
  assign rnd = (shift_q == '0) ? '0 : (ONE << (shift_q - SHIFT_W'(1)));

  for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_ch
    localparam int RI = i % FM_DEPTH;

    logic signed [P_W-1:0]        a_ext;
    logic signed [P_W-1:0]        x_ext;
    logic signed [P_W-1:0]        p_q;
    logic signed [Q_W-1:0]        b_ext;
    logic signed [Q_W-1:0]        r_ext;
    logic signed [Q_W-1:0]        q_q;
    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      sum;
    logic signed [ACC_W-1:0]      shifted;
    logic                         hi;
    logic                         lo;
    logic [DATA_WIDTH-1:0]        y_q;

    assign a_ext = P_W'(signed'(bn_a[i*PARA_WIDTH +: PARA_WIDTH]));
    assign x_ext = P_W'(signed'(data_in[i*DATA_WIDTH +: DATA_WIDTH]));
    assign b_ext = Q_W'(signed'(bn_b[i*PARA_WIDTH +: PARA_WIDTH]));
    assign r_ext = res_en ? Q_W'(signed'(res[RI*DATA_WIDTH +: DATA_WIDTH])) : '0;

    // Stage 1 registers only load on an accepted beat. Their contents are invisible
    // otherwise, because stage 2 only loads when s1_v is set.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p_q <= '0;
        q_q <= '0;
      end else if (accept) begin
        p_q <= a_ext * x_ext;
        q_q <= b_ext + r_ext;
      end
    end

    assign acc     = ACC_W'(p_q) + ACC_W'(q_q);
    assign sum     = acc + rnd;
    assign shifted = sum >>> shift_q;
    assign hi      = shifted > SAT_MAX;
    assign lo      = shifted < SAT_MIN;
    assign clamped[i] = hi | lo;

    // data_out keeps its last value across bubbles. It only loads when a valid
    // beat moves into the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        y_q <= '0;
      end else if (adv && s1_v) begin
        y_q <= hi ? SAT_MAX[DATA_WIDTH-1:0] :
               lo ? SAT_MIN[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
      end
    end

    assign data_out[i*DATA_WIDTH +: DATA_WIDTH] = y_q;
  end

  // Pipeline valids, shift capture and sat flag.
  // Reload mode has priority over a stall, so in-flight beats are dropped even while
  // the output is backpressured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v       <= 1'b0;
      data_e_out <= 1'b0;
      sat_flag   <= 1'b0;
      shift_q    <= '0;
    end else if (!mode) begin
      s1_v       <= 1'b0;
      data_e_out <= 1'b0;
      sat_flag   <= 1'b0;
      shift_q    <= shift_cfg;
    end else if (!stall) begin
      s1_v       <= accept;
      data_e_out <= s1_v;
      sat_flag   <= s1_v && (|clamped);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= 1'b0;
      sat_cnt <= '0;
    end else begin
      mode_q <= mode;
      if (mode_q && !mode) begin
        sat_cnt <= '0;
      end else if (retire && sat_flag && (sat_cnt != '1)) begin
        sat_cnt <= sat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bn_res_pipe.sv
module tb_bn_res_pipe;
  localparam int DW = 16;
  localparam int PW = 16;
  localparam int CH = 256;
  localparam int FM = 128;

  logic              clk;
  logic              rst_n;
  logic              mode;
  logic [3:0]        shift_cfg;
  logic              res_en;
  logic [DW*CH-1:0]  data_in;
  logic              data_e;
  logic              data_ready;
  logic [PW*CH-1:0]  bn_a;
  logic [PW*CH-1:0]  bn_b;
  logic [DW*FM-1:0]  res;
  logic [DW*CH-1:0]  data_out;
  logic              data_e_out;
  logic              out_ready;
  logic              sat_flag;
  logic [15:0]       sat_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          ramp;
    logic [15:0] val;
    bit          sat;
  } exp_t;
  exp_t sbq[$];

  exp_t        mon_e;
  int          mon_bad;
  logic [15:0] mon_ev;
  logic [15:0] mon_av;
  logic [15:0] mon_xv;

  bn_res_pipe #(
    .DATA_WIDTH(DW), .PARA_WIDTH(PW), .CHANNEL_NUM(CH),
    .FM_DEPTH(FM), .SHIFT_W(4), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .shift_cfg(shift_cfg), .res_en(res_en),
    .data_in(data_in), .data_e(data_e), .data_ready(data_ready),
    .bn_a(bn_a), .bn_b(bn_b), .res(res),
    .data_out(data_out), .data_e_out(data_e_out), .out_ready(out_ready),
    .sat_flag(sat_flag), .sat_cnt(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input bit ramp, input logic [15:0] v, input bit s);
    exp_t e;
    e.ramp = ramp;
    e.val  = v;
    e.sat  = s;
    return e;
  endfunction

  // Monitor: compares every retired beat against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && data_e_out && out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat actual=data_e_out=1 required=no_beat");
      end else begin
        mon_e = sbq.pop_front();
        mon_bad = -1;
        for (int c = 0; c < CH; c++) begin
          mon_ev = mon_e.ramp ? 16'(c % FM) : mon_e.val;
          if (data_out[c*DW +: DW] !== mon_ev && mon_bad < 0) begin
            mon_bad = c;
            mon_av  = data_out[c*DW +: DW];
            mon_xv  = mon_ev;
          end
        end
        if (mon_bad >= 0) begin
          failures++;
          $display("FAIL beat_data ch=%0d actual=%h required=%h", mon_bad, mon_av, mon_xv);
        end
        checks++;
        if (sat_flag !== mon_e.sat) begin
          failures++;
          $display("FAIL beat_sat_flag actual=%b required=%b", sat_flag, mon_e.sat);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_uniform(input int a, input int x, input int b, input int r);
    for (int c = 0; c < CH; c++) begin
      bn_a[c*PW +: PW]    = 16'(a);
      data_in[c*DW +: DW] = 16'(x);
      bn_b[c*PW +: PW]    = 16'(b);
    end
    for (int j = 0; j < FM; j++) res[j*DW +: DW] = 16'(r);
  endtask

  // Present a beat and wait (bounded) until it is accepted. Returns #1 after the accept edge.
  task automatic send(input bit push, input exp_t e);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    data_e = 1'b1;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = data_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end else if (push) begin
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 64'(sbq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic reload(input logic [3:0] s);
    mode = 1'b0;
    shift_cfg = s;
    @(posedge clk);
    #1;
    mode = 1'b1;
  endtask

  logic [DW*CH-1:0] held;
  bit               seen;

  initial begin
    rst_n = 1'b0; mode = 1'b1; shift_cfg = '0; res_en = 1'b0; data_e = 1'b0;
    out_ready = 1'b1; data_in = '0; bn_a = '0; bn_b = '0; res = '0;

    // reset state
    #3;
    check("rst_data_e_out", 64'(data_e_out), 64'd0);
    check("rst_sat_flag", 64'(sat_flag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_data_ready", 64'(data_ready), 64'd1);
    check("rst_data_out", 64'(data_out == '0), 64'd1);
    check("rst_sat_cnt", 64'(sat_cnt), 64'd0);

    // T1: 2*100 + 5 + 7 = 212, latency
    reload(4'd0);
    set_uniform(2, 100, 5, 7);
    res_en = 1'b1;
    send(1'b1, mk(1'b0, 16'd212, 1'b0));
    data_e = 1'b0;
    check("lat_after_accept", 64'(data_e_out), 64'd0);
    @(posedge clk);
    #1;
    check("lat_second_edge", 64'(data_e_out), 64'd1);
    check("lat_data_ch0", 64'(data_out[15:0]), 64'd212);
    drain();

    // T2: shift 4, round half up
    reload(4'd4);
    res_en = 1'b0;
    set_uniform(1, 23, 0, 0);
    send(1'b1, mk(1'b0, 16'd1, 1'b0));
    set_uniform(1, -24, 0, 0);
    send(1'b1, mk(1'b0, 16'hffff, 1'b0));
    data_e = 1'b0;
    drain();

    // T3: saturation both ways
    reload(4'd0);
    set_uniform(32767, 32767, 0, 0);
    send(1'b1, mk(1'b0, 16'h7fff, 1'b1));
    set_uniform(32767, -32768, 0, 0);
    send(1'b1, mk(1'b0, 16'h8000, 1'b1));
    data_e = 1'b0;
    drain();
    check("t3_sat_cnt", 64'(sat_cnt), 64'd2);

    // T4: residual replication and gating
    set_uniform(0, 0, 0, 0);
    for (int j = 0; j < FM; j++) res[j*DW +: DW] = 16'(j);
    res_en = 1'b1;
    send(1'b1, mk(1'b1, 16'd0, 1'b0));
    res_en = 1'b0;
    send(1'b1, mk(1'b0, 16'd0, 1'b0));
    data_e = 1'b0;
    drain();

    // T5: stream of 6 with a 3-cycle downstream stall
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          set_uniform(1, 10 * (k + 1), 0, 0);
          send(1'b1, mk(1'b0, 16'(10 * (k + 1)), 1'b0));
        end
        data_e = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        held = data_out;
        check("t5_stall_valid", 64'(data_e_out), 64'd1);
        check("t5_stall_ready", 64'(data_ready), 64'd0);
        repeat (2) begin
          @(negedge clk);
          check("t5_stall_ready", 64'(data_ready), 64'd0);
          check("t5_hold_data", 64'(data_out == held), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // T6: reload with two beats in flight drops them and clears sat_cnt
    check("t6_sat_cnt_before", 64'(sat_cnt), 64'd2);
    out_ready = 1'b0;
    set_uniform(1, 7, 0, 0);
    send(1'b0, mk(1'b0, 16'd7, 1'b0));
    send(1'b0, mk(1'b0, 16'd7, 1'b0));
    data_e = 1'b0;
    mode = 1'b0;
    @(posedge clk);
    #1;
    check("t6_flush_valid", 64'(data_e_out), 64'd0);
    check("t6_sat_cnt_clr", 64'(sat_cnt), 64'd0);
    check("t6_ready_low", 64'(data_ready), 64'd0);
    mode = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (data_e_out) seen = 1'b1;
    end
    check("t6_no_output", 64'(seen), 64'd0);

    // reset pulse mid-stream
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    set_uniform(1, 9, 0, 0);
    send(1'b0, mk(1'b0, 16'd9, 1'b0));
    send(1'b0, mk(1'b0, 16'd9, 1'b0));
    data_e = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_data_out", 64'(data_out == '0), 64'd1);
    check("mid_rst_valid", 64'(data_e_out), 64'd0);
    check("mid_rst_sat_flag", 64'(sat_flag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 64'(data_ready), 64'd1);
    check("post_rst_valid", 64'(data_e_out), 64'd0);
    set_uniform(1, 5, 0, 0);
    send(1'b1, mk(1'b0, 16'd5, 1'b0));
    data_e = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
